// File: rtl/snes_pad_emulator.sv
// SNES controller-side emulator: answers a host's dlatch/dclock with 16 serial
// bits (12 buttons + 4 ID bits) on data, active-low, sampled on the system clock.
module snes_pad_emulator #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [3:0]  ID_BITS     = 4'b0000,
  parameter logic        FILL_LEVEL  = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       a,
  input  logic       b,
  input  logic       x,
  input  logic       y,
  input  logic       start,
  input  logic       sel,
  input  logic       l,
  input  logic       r,
  input  logic       dlatch,
  input  logic       dclock,
  output logic       data,
  output logic       busy,
  output logic       frame_done,
  output logic [4:0] bits_sent
);

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_latch_sync, r_clk_sync;
  logic                    r_latch_prev, r_clk_prev;
  logic [FRAME_BITS-1:0]   r_sr, w_sr_nxt;
  logic                    r_data, w_data_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_frame_done, w_frame_done_nxt;
  logic [CNT_W-1:0]        r_bits, w_bits_nxt;

  logic                    w_latch_s, w_clk_s;
  logic                    w_latch_fall, w_clk_rise;
  logic [FRAME_BITS-1:0]   w_snapshot;

  // Synchronisers plus one history stage; reset values match the idle line levels
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_latch_sync <= '0;
      r_clk_sync   <= '1;
      r_latch_prev <= 1'b0;
      r_clk_prev   <= 1'b1;
    end else begin
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], dlatch};
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], dclock};
      r_latch_prev <= w_latch_s;
      r_clk_prev   <= w_clk_s;
    end
  end

  assign w_latch_s    = r_latch_sync[SYNC_STAGES-1];
  assign w_clk_s      = r_clk_sync[SYNC_STAGES-1];
  assign w_latch_fall = ~w_latch_s & r_latch_prev;
  assign w_clk_rise   = w_clk_s & ~r_clk_prev;

  // Index 0 is the first bit on the wire
  assign w_snapshot = {ID_BITS, r, l, x, a, right, left, down, up, start, sel, y, b};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_sr         <= '0;
      r_data       <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_bits       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sr         <= w_sr_nxt;
      r_data       <= w_data_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_bits       <= w_bits_nxt;
    end
  end

  // A high latch overrides everything, including a coincident dclock rise
  always_comb begin
    w_state_nxt      = r_state;
    w_sr_nxt         = r_sr;
    w_data_nxt       = r_data;
    w_busy_nxt       = r_busy;
    w_frame_done_nxt = 1'b0;
    w_bits_nxt       = r_bits;

    if (w_latch_s) begin
      w_state_nxt = S_LOAD;
      w_sr_nxt    = w_snapshot;
      w_data_nxt  = ~w_snapshot[0];
      w_busy_nxt  = 1'b0;
      w_bits_nxt  = '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_latch_fall) begin
            w_state_nxt = S_SHIFT;
            w_busy_nxt  = 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_clk_rise) begin
            w_sr_nxt = {1'b0, r_sr[FRAME_BITS-1:1]};
            if (r_bits == CNT_W'(FRAME_BITS - 1)) begin
              w_state_nxt      = S_DONE;
              w_bits_nxt       = CNT_W'(FRAME_BITS);
              w_frame_done_nxt = 1'b1;
              w_busy_nxt       = 1'b0;
              w_data_nxt       = FILL_LEVEL;
            end else begin
              w_bits_nxt = r_bits + CNT_W'(1);
              w_data_nxt = ~r_sr[1];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign data       = r_data;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign bits_sent  = r_bits;

endmodule

// File: tb/tb_snes_pad_emulator.sv
// Bench for snes_pad_emulator: plays the host side of the pad protocol and
// compares each sampled bit with the frame predicted from the latched buttons.
module tb_snes_pad_emulator;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned HALF  = 20;
  localparam int unsigned LATCH = 30;
  localparam logic [3:0]  ID    = 4'b0000;
  localparam logic        FILL  = 1'b0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] btn = '0;
  logic        dlatch = 1'b0;
  logic        dclock = 1'b1;
  logic        data, busy, frame_done;
  logic [4:0]  bits_sent;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clock = ~clock;

  // btn is held in wire order: b, y, sel, start, up, down, left, right, a, x, l, r
  snes_pad_emulator #(.SYNC_STAGES(SYNC), .ID_BITS(ID), .FILL_LEVEL(FILL)) dut (
    .clock(clock), .reset_n(reset_n),
    .up(btn[4]), .down(btn[5]), .left(btn[6]), .right(btn[7]),
    .a(btn[8]), .b(btn[0]), .x(btn[9]), .y(btn[1]),
    .start(btn[3]), .sel(btn[2]), .l(btn[10]), .r(btn[11]),
    .dlatch(dlatch), .dclock(dclock),
    .data(data), .busy(busy), .frame_done(frame_done), .bits_sent(bits_sent)
  );

  always @(negedge clock) if (frame_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level the host should see at its k-th dclock fall (0 = pressed)
  function automatic logic exp_line(input logic [11:0] snap, input int k);
    logic [15:0] f;
    f = {ID, snap};
    if (k >= 16) return FILL;
    return ~f[k];
  endfunction

  task automatic clocks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input logic [11:0] snap, input logic [11:0] after, input int n);
    int d0;
    d0 = done_cnt;
    btn = snap;
    clocks(2);
    dlatch = 1'b1;
    clocks(LATCH);
    dlatch = 1'b0;
    clocks(6);
    chk("busy_after_latch", 16'(busy), 16'(1));
    chk("bits_after_latch", 16'(bits_sent), 16'(0));
    btn = after;
    clocks(HALF - 6);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("sample_%0d", k), 16'(data), 16'(exp_line(snap, k)));
      dclock = 1'b0;
      clocks(HALF);
      dclock = 1'b1;
      clocks(HALF);
    end
    chk("bits_sent_end", 16'(bits_sent), 16'((n > 16) ? 16 : n));
    chk("busy_end", 16'(busy), 16'(n < 16));
    if (n >= 16) chk("fill_end", 16'(data), 16'(FILL));
    chk("frame_done_count", 16'(done_cnt - d0), 16'((n >= 16) ? 1 : 0));
  endtask

  initial begin
    logic [11:0] s, t;

    // Reset and idle, including dclock activity that IDLE must ignore
    repeat (3) @(posedge clock);
    #1;
    chk("rst_data", 16'(data), 16'(1));
    chk("rst_busy", 16'(busy), 16'(0));
    chk("rst_bits", 16'(bits_sent), 16'(0));
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clocks(10);
      chk("idle_data", 16'(data), 16'(1));
      chk("idle_busy", 16'(busy), 16'(0));
      chk("idle_bits", 16'(bits_sent), 16'(0));
    end
    for (int i = 0; i < 3; i++) begin
      dclock = 1'b0; clocks(HALF);
      dclock = 1'b1; clocks(HALF);
    end
    chk("idle_dclk_data", 16'(data), 16'(1));
    chk("idle_dclk_bits", 16'(bits_sent), 16'(0));
    chk("idle_no_done", 16'(done_cnt), 16'(0));

    // b, up and r pressed
    run_frame(12'h811, 12'h811, 16);

    // a released after the latch fall must not change bit 8
    run_frame(12'h100, 12'h000, 16);

    // Over-clocking past the end of the frame
    s = 12'($urandom);
    run_frame(s, s, 20);

    // Relatch after 5 bits, then a frame with only x pressed
    s = 12'($urandom);
    run_frame(s, s, 5);
    run_frame(12'h200, 12'h200, 16);

    // Asynchronous reset mid-frame, checked before any clock edge
    s = 12'($urandom);
    run_frame(s, s, 7);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_data", 16'(data), 16'(1));
    chk("async_rst_busy", 16'(busy), 16'(0));
    chk("async_rst_bits", 16'(bits_sent), 16'(0));
    clocks(3);
    reset_n = 1'b1;
    clocks(5);
    s = 12'($urandom);
    run_frame(s, s, 16);

    // Random buttons, random changes after the latch, random overrun
    for (int i = 0; i < 6; i++) begin
      s = 12'($urandom);
      t = 12'($urandom);
      run_frame(s, t, int'($urandom_range(16, 19)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
